axivideo_sync: RTL and testbench

Frame-alignment stage for AXI video streams. Accepts a pixel stream from a source whose framing markers may be out of step or corrupt, such as a camera or a stream joined mid-frame, and discards pixels until a frame start is found. It then forwards whole frames with TLAST/TUSER regenerated from internal x/y counters. Sits directly upstream of any consumer that requires strictly well-formed framing, such as the frame buffer writer or the video output stage.

---
 rtl/axivideo_sync.sv | 145 ++++++++++++++
 tb/tb_axivideo_sync.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/axivideo_sync.sv
// Frame-alignment stage for AXI video: drops input until a frame start, then
// forwards whole frames with TLAST/TUSER regenerated from x/y counters.
// Optional: define AXIVIDEO_SYNC_STATS_EN to add the o_err_count port.
module axivideo_sync #(
    parameter int PW               = 24,
    parameter int LGDIM            = 10,
    parameter bit OPT_TUSER_IS_SOF = 1'b1
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic             S_VID_TVALID,
    output logic             S_VID_TREADY,
    input  logic [PW-1:0]    S_VID_TDATA,
    input  logic             S_VID_TLAST,
    input  logic             S_VID_TUSER,
    output logic             M_VID_TVALID,
    input  logic             M_VID_TREADY,
    output logic [PW-1:0]    M_VID_TDATA,
    output logic             M_VID_TLAST,
    output logic             M_VID_TUSER,
    input  logic [LGDIM-1:0] i_width,
    input  logic [LGDIM-1:0] i_height,
    output logic             o_in_sync,
`ifdef AXIVIDEO_SYNC_STATS_EN
    output logic             o_sync_err,
    output logic [15:0]      o_err_count
`else
    output logic             o_sync_err
`endif
);

    typedef enum logic {S_WAIT, S_PASS} state_t;

    state_t            state, state_next;
    logic [LGDIM-1:0]  x, y, w, h;
    logic [LGDIM-1:0]  cur_x, cur_y, cur_w, cur_h;
    logic              x_end, y_end;
    logic              exp_last, exp_user;
    logic              accept, mismatch, sof, load;

    assign S_VID_TREADY = (state == S_WAIT) || !M_VID_TVALID || M_VID_TREADY;
    assign accept       = S_VID_TVALID && S_VID_TREADY;

    // In WAIT the pixel under test is evaluated as position (0,0) of a new frame
    always_comb begin
        cur_x    = (state == S_PASS) ? x : '0;
        cur_y    = (state == S_PASS) ? y : '0;
        cur_w    = (state == S_PASS) ? w : i_width;
        cur_h    = (state == S_PASS) ? h : i_height;
        x_end    = ({1'b0, cur_x} + (LGDIM+1)'(1)) == {1'b0, cur_w};
        y_end    = ({1'b0, cur_y} + (LGDIM+1)'(1)) == {1'b0, cur_h};
        exp_user = 1'b0;
        exp_last = 1'b0;
        if (OPT_TUSER_IS_SOF) begin
            exp_user = (cur_x == '0) && (cur_y == '0);
            exp_last = x_end;
        end else begin
            exp_user = x_end;
            exp_last = x_end && y_end;
        end
    end

    assign mismatch = accept && (state == S_PASS) &&
                      ((S_VID_TLAST != exp_last) || (S_VID_TUSER != exp_user));
    assign sof      = accept && (state == S_WAIT) &&
                      (OPT_TUSER_IS_SOF ? S_VID_TUSER : S_VID_TLAST);
    assign load     = accept && (((state == S_PASS) && !mismatch) ||
                                 (OPT_TUSER_IS_SOF && sof));

    always_ff @(posedge i_clk) begin
        if (!i_reset_n)
            state <= S_WAIT;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_WAIT:  if (sof)      state_next = S_PASS;
            S_PASS:  if (mismatch) state_next = S_WAIT;
            default:               state_next = S_WAIT;
        endcase
    end

    // Position counters; dimensions are only sampled at sync and at frame wrap
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            x <= '0;
            y <= '0;
        end else if (mismatch) begin
            x <= '0;
            y <= '0;
        end else if (sof && !OPT_TUSER_IS_SOF) begin
            x <= '0;
            y <= '0;
            w <= i_width;
            h <= i_height;
        end else if (load) begin
            if (state == S_WAIT || (x_end && y_end)) begin
                w <= i_width;
                h <= i_height;
            end
            if (x_end) begin
                x <= '0;
                y <= y_end ? '0 : cur_y + LGDIM'(1);
            end else begin
                x <= cur_x + LGDIM'(1);
                y <= cur_y;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            M_VID_TVALID <= 1'b0;
            M_VID_TDATA  <= '0;
            M_VID_TLAST  <= 1'b0;
            M_VID_TUSER  <= 1'b0;
            o_in_sync    <= 1'b0;
            o_sync_err   <= 1'b0;
        end else begin
            if (load) begin
                M_VID_TVALID <= 1'b1;
                M_VID_TDATA  <= S_VID_TDATA;
                M_VID_TLAST  <= exp_last;
                M_VID_TUSER  <= exp_user;
            end else if (M_VID_TREADY) begin
                M_VID_TVALID <= 1'b0;
            end
            o_in_sync  <= (state_next == S_PASS);
            o_sync_err <= mismatch;
        end
    end

`ifdef AXIVIDEO_SYNC_STATS_EN
    always_ff @(posedge i_clk) begin
        if (!i_reset_n)
            o_err_count <= '0;
        else if (o_sync_err && (o_err_count != 16'hffff))
            o_err_count <= o_err_count + 16'd1;
    end
`endif

endmodule

// File: tb/tb_axivideo_sync.sv
// Scoreboard bench for axivideo_sync: instance 0 runs TUSER=EOL/TLAST=EOF,
// instance 1 runs TUSER=SOF/TLAST=EOL.
module tb_axivideo_sync;
    localparam int PW    = 24;
    localparam int LGDIM = 10;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    logic             s_valid [2];
    logic [PW-1:0]    s_data  [2];
    logic             s_last  [2];
    logic             s_user  [2];
    logic             m_ready [2];
    logic [LGDIM-1:0] width   [2];
    logic [LGDIM-1:0] height  [2];
    wire              s_ready [2];
    wire              m_valid [2];
    wire  [PW-1:0]    m_data  [2];
    wire              m_last  [2];
    wire              m_user  [2];
    wire              in_sync [2];
    wire              sync_err[2];
`ifdef AXIVIDEO_SYNC_STATS_EN
    wire  [15:0]      err_count[2];
`endif

    axivideo_sync #(.PW(PW), .LGDIM(LGDIM), .OPT_TUSER_IS_SOF(1'b0)) dut0 (
        .i_clk(clk), .i_reset_n(rst_n),
        .S_VID_TVALID(s_valid[0]), .S_VID_TREADY(s_ready[0]), .S_VID_TDATA(s_data[0]),
        .S_VID_TLAST(s_last[0]), .S_VID_TUSER(s_user[0]),
        .M_VID_TVALID(m_valid[0]), .M_VID_TREADY(m_ready[0]), .M_VID_TDATA(m_data[0]),
        .M_VID_TLAST(m_last[0]), .M_VID_TUSER(m_user[0]),
        .i_width(width[0]), .i_height(height[0]),
`ifdef AXIVIDEO_SYNC_STATS_EN
        .o_err_count(err_count[0]),
`endif
        .o_in_sync(in_sync[0]), .o_sync_err(sync_err[0]));

    axivideo_sync #(.PW(PW), .LGDIM(LGDIM), .OPT_TUSER_IS_SOF(1'b1)) dut1 (
        .i_clk(clk), .i_reset_n(rst_n),
        .S_VID_TVALID(s_valid[1]), .S_VID_TREADY(s_ready[1]), .S_VID_TDATA(s_data[1]),
        .S_VID_TLAST(s_last[1]), .S_VID_TUSER(s_user[1]),
        .M_VID_TVALID(m_valid[1]), .M_VID_TREADY(m_ready[1]), .M_VID_TDATA(m_data[1]),
        .M_VID_TLAST(m_last[1]), .M_VID_TUSER(m_user[1]),
        .i_width(width[1]), .i_height(height[1]),
`ifdef AXIVIDEO_SYNC_STATS_EN
        .o_err_count(err_count[1]),
`endif
        .o_in_sync(in_sync[1]), .o_sync_err(sync_err[1]));

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Expected output words are {data, tlast, tuser}
    logic [PW+1:0] q0[$];
    logic [PW+1:0] q1[$];
    bit            mon_en[2];
    int            n_out[2];
    int            n_err[2];
    bit            bp_en;
    int            bp_phase;

    function automatic int qsize(input int m);
        return (m == 0) ? q0.size() : q1.size();
    endfunction

    function automatic logic [PW+1:0] qfront(input int m);
        return (m == 0) ? q0[0] : q1[0];
    endfunction

    task automatic qpush(input int m, input logic [PW+1:0] v);
        if (m == 0) q0.push_back(v); else q1.push_back(v);
    endtask

    task automatic qpop(input int m);
        if (m == 0) void'(q0.pop_front()); else void'(q1.pop_front());
    endtask

    always @(negedge clk) begin
        for (int m = 0; m < 2; m++) begin
            if (sync_err[m]) n_err[m]++;
            if (mon_en[m] && m_valid[m]) begin
                if (qsize(m) == 0) begin
                    check("spurious_out", 32'(m_valid[m]), 32'd0);
                end else if (m_ready[m]) begin
                    check("out", 32'({m_data[m], m_last[m], m_user[m]}), 32'(qfront(m)));
                    qpop(m);
                    n_out[m]++;
                end else begin
                    check("out_held", 32'({m_data[m], m_last[m], m_user[m]}), 32'(qfront(m)));
                    check("s_ready_held", 32'(s_ready[m]), 32'd0);
                end
            end
        end
    end

    task automatic step_bp();
        if (bp_en) begin
            m_ready[1] = (bp_phase == 0) || (bp_phase == 3);
            bp_phase   = (bp_phase + 1) % 4;
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            step_bp();
        end
    endtask

    task automatic send(input int m, input logic [PW-1:0] d, input logic l,
                        input logic u, input bit exp);
        int t;
        t = 0;
        s_valid[m] = 1'b1;
        s_data[m]  = d;
        s_last[m]  = l;
        s_user[m]  = u;
        if (exp) qpush(m, {d, l, u});
        forever begin
            @(negedge clk);
            if (s_ready[m]) break;
            t++;
            if (t > 200) begin
                check("src_timeout", 32'(s_ready[m]), 32'd1);
                break;
            end
            @(posedge clk); #1;
            step_bp();
        end
        @(posedge clk); #1;
        s_valid[m] = 1'b0;
        if (exp) begin
            check("latency_vld", 32'(m_valid[m]), 32'd1);
            check("latency_data", 32'(m_data[m]), 32'(d));
        end
        step_bp();
    endtask

    // SOF/EOL convention frame, pixels k0..w*h-1
    task automatic frame1(input int w, input int h, input int k0, input bit exp);
        for (int k = k0; k < w * h; k++)
            send(1, PW'($urandom), (k % w) == w - 1, k == 0, exp);
    endtask

    // EOL/EOF convention frame
    task automatic frame0(input int w, input int h, input int k0, input bit exp);
        for (int k = k0; k < w * h; k++)
            send(0, PW'($urandom), k == w * h - 1, (k % w) == w - 1, exp);
    endtask

    initial begin
        for (int m = 0; m < 2; m++) begin
            s_valid[m] = 1'b0; s_data[m] = '0; s_last[m] = 1'b0; s_user[m] = 1'b0;
            m_ready[m] = 1'b1; mon_en[m] = 1'b1; n_out[m] = 0; n_err[m] = 0;
        end
        width[0] = 10'd3; height[0] = 10'd3;
        width[1] = 10'd4; height[1] = 10'd3;
        bp_en = 1'b0; bp_phase = 0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_m_valid", 32'(m_valid[1]), 32'd0);
        check("rst_m_data", 32'(m_data[1]), 32'd0);
        check("rst_m_last", 32'(m_last[1]), 32'd0);
        check("rst_m_user", 32'(m_user[1]), 32'd0);
        check("rst_in_sync", 32'(in_sync[1]), 32'd0);
        check("rst_sync_err", 32'(sync_err[1]), 32'd0);
        check("rst_m_valid0", 32'(m_valid[0]), 32'd0);
        rst_n = 1'b1;
        tick(1);

        // Joined mid-frame: drop until SOF, then a clean 4x3 frame
        frame1(4, 3, 5, 1'b0);
        check("wait_in_sync", 32'(in_sync[1]), 32'd0);
        frame1(4, 3, 0, 1'b1);
        tick(3);
        check("t1_n_out", 32'(n_out[1]), 32'd12);
        check("t1_q_empty", 32'(qsize(1)), 32'd0);
        check("t1_errs", 32'(n_err[1]), 32'd0);
        check("t1_in_sync", 32'(in_sync[1]), 32'd1);

        // Early TLAST at x=2 of line 1
        for (int k = 0; k < 6; k++)
            send(1, PW'($urandom), (k % 4) == 3, k == 0, 1'b1);
        send(1, PW'($urandom), 1'b1, 1'b0, 1'b0);
        check("t2_err_pulse", 32'(sync_err[1]), 32'd1);
        check("t2_in_sync", 32'(in_sync[1]), 32'd0);
        frame1(4, 3, 7, 1'b0);
        frame1(4, 3, 0, 1'b1);
        tick(3);
        check("t2_errs", 32'(n_err[1]), 32'd1);
        check("t2_q_empty", 32'(qsize(1)), 32'd0);
        check("t2_n_out", 32'(n_out[1]), 32'd30);
`ifdef AXIVIDEO_SYNC_STATS_EN
        check("t2_err_count", 32'(err_count[1]), 32'd1);
`endif

        // Backpressure 1,0,0,1
        bp_en = 1'b1;
        frame1(4, 3, 0, 1'b1);
        tick(8);
        bp_en = 1'b0;
        m_ready[1] = 1'b1;
        tick(2);
        check("t3_q_empty", 32'(qsize(1)), 32'd0);
        check("t3_n_out", 32'(n_out[1]), 32'd42);
        check("t3_errs", 32'(n_err[1]), 32'd1);

        // Reset with a held output pending
        mon_en[1]  = 1'b0;
        m_ready[1] = 1'b0;
        send(1, PW'($urandom), 1'b0, 1'b1, 1'b0);
        check("t4_held", 32'(m_valid[1]), 32'd1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("t4_rst_valid", 32'(m_valid[1]), 32'd0);
        check("t4_rst_in_sync", 32'(in_sync[1]), 32'd0);
        rst_n = 1'b1;
        m_ready[1] = 1'b1;
        mon_en[1]  = 1'b1;
        tick(1);
        frame1(4, 3, 1, 1'b0);
        frame1(4, 3, 0, 1'b1);
        tick(3);
        check("t4_q_empty", 32'(qsize(1)), 32'd0);
        check("t4_n_out", 32'(n_out[1]), 32'd54);

        // Width change mid-frame takes effect at the next frame
        for (int k = 0; k < 2; k++)
            send(1, PW'($urandom), 1'b0, k == 0, 1'b1);
        width[1] = 10'd6;
        frame1(4, 3, 2, 1'b1);
        frame1(6, 3, 0, 1'b1);
        tick(3);
        check("t5_q_empty", 32'(qsize(1)), 32'd0);
        check("t5_n_out", 32'(n_out[1]), 32'd84);
        check("t5_errs", 32'(n_err[1]), 32'd1);

        // EOL/EOF convention: sync on TLAST, that pixel is dropped
        send(0, PW'($urandom), 1'b1, 1'b1, 1'b0);
        frame0(3, 3, 0, 1'b1);
        tick(3);
        check("m0_n_out", 32'(n_out[0]), 32'd9);
        check("m0_q_empty", 32'(qsize(0)), 32'd0);
        check("m0_errs", 32'(n_err[0]), 32'd0);
        check("m0_in_sync", 32'(in_sync[0]), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
